irq_priority_ctrl: RTL
======================

// Module: irq_priority_ctrl
// PURPOSE
//  Parametrised interrupt controller for the monocycle CPU; successor to the combinational one-hot priority picker.
//  Latches rising edges on N_IRQ request lines into a pending register and masks them.
//  Selects the lowest-index unmasked pending line (a & -a priority) and presents it to the CPU via a req/ack handshake.
//  Tracks in-service state until the CPU signals end-of-interrupt (EOI).
// PARAMETERS
//  N_IRQ  8  number of interrupt lines; index 0 = highest priority
//  ID_W   3  width of encoded id; 2**ID_W >= N_IRQ required
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  reset       in   1      asynchronous, active-high; clears all state
//  irq_in      in   N_IRQ  raw request lines, edge-sensitive (0->1)
//  mask_we     in   1      load mask register from mask_wd this cycle
//  mask_wd     in   N_IRQ  new mask; bit=1 blocks that line from selection
//  irq_ack     in   1      CPU accepts presented interrupt (honoured only in REQ)
//  irq_eoi     in   1      CPU finished current handler (honoured only in SERVICE)
//  irq_req     out  1      interrupt presented to CPU
//  irq_id      out  ID_W   encoded index of presented line, stable while irq_req=1
//  irq_onehot  out  N_IRQ  one-hot of irq_id while irq_req=1, else 0
//  in_service  out  N_IRQ  in-service register (isr)
//  pending     out  N_IRQ  pending register
// BEHAVIOUR
//  - Reset: pending, mask, isr, prev_irq, irq_id = 0; irq_req = 0; state = IDLE. Applies mid-handshake too; no event survives.
//  - Edge detect: prev_irq <= irq_in every cycle.
//    Edge on bit i = irq_in[i] & ~prev_irq[i] -> pending[i] <= 1 at that posedge.
//  - Masking gates selection only; masked edges still set pending.
//    mask_we updates the mask at the posedge; the new mask affects selection from the next cycle.
//  - cand = pending & ~mask; sel = cand & -cand (lowest set bit).
//    top_isr = isr & -isr.
//  - States:
//    IDLE    : cand!=0 -> REQ; latch irq_id = index(sel).
//    REQ     : irq_req=1. On irq_ack:
//              pending[irq_id] <= 0; isr[irq_id] <= 1; -> SERVICE.
//              irq_id is not retracted if its line is masked meanwhile.
//    SERVICE : on irq_eoi: isr <= isr & ~top_isr.
//              Next state is IDLE if the resulting isr == 0, else SERVICE.
//  - Latency: irq_in first sampled high at edge k -> pending set after k -> irq_req=1 after edge k+1.
//    irq_ack at edge m -> isr set and irq_req=0 after m.
//  - Simultaneous edge and ack on the same bit: set wins; pending stays 1, isr bit set.
//  - irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
//    Exception: with nesting enabled, irq_eoi in REQ is also ignored.
//  - irq_req is a registered output; no combinational path from any input.
// CONFIGURATION
//  IRQ_NEST_EN defined:
//    - In SERVICE, if cand!=0 and index(sel) < index(top_isr), go to REQ presenting sel (preemption).
//    - isr may hold several bits.
//    - After EOI, go to REQ directly if a higher candidate than the new top_isr exists, or if isr is 0 and cand!=0.
//  IRQ_NEST_EN undefined:
//    - No request is raised while in SERVICE; isr holds at most one bit.
//    - After EOI, state returns to IDLE.
// TESTING
//  1 reset: assert reset mid-REQ with pending=8'h05 -> all outputs 0 same cycle, state IDLE.
//  2 single: irq_in[3] 0->1, mask=0 -> irq_req=1, irq_id=3, irq_onehot=8'h08 two edges later;
//    ack -> isr=8'h08, pending=0; eoi -> isr=0, IDLE.
//  3 priority: irq_in[5] and irq_in[2] rise together -> id=2 first;
//    after ack+eoi -> id=5 presented, pending=8'h00 after second ack.
//  4 mask: mask=8'h04, irq_in[2] rises -> pending=8'h04, no irq_req;
//    write mask=0 -> irq_req=1, id=2 two edges later.
//  5 race: irq_in[1] rises on the ack edge of id 1 -> pending[1]=1, isr[1]=1;
//    after eoi id=1 is re-presented.
//  6 nesting (IRQ_NEST_EN): in SERVICE on id 4, irq_in[0] rises -> REQ id=0; ack -> isr=8'h11;
//    eoi -> isr=8'h10; eoi -> IDLE.
//    Without the macro, id 0 waits until after the eoi of 4.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Interrupt controller: edge-latched pending lines, masking, lowest-index priority, req/ack/EOI handshake.
// Optional nesting/preemption is enabled by defining IRQ_NEST_EN.
module irq_priority_ctrl #(
   parameter int N_IRQ = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wd,
   input  logic             irq_ack,
   input  logic             irq_eoi,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_IRQ-1:0] irq_onehot,
   output logic [N_IRQ-1:0] in_service,
   output logic [N_IRQ-1:0] pending
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t           state, state_n;
   logic [N_IRQ-1:0] pending_q, pending_n;
   logic [N_IRQ-1:0] isr_q, isr_n;
   logic [N_IRQ-1:0] mask_q;
   logic [N_IRQ-1:0] prev_irq;
   logic [ID_W-1:0]  id_q, id_n;
   logic [N_IRQ-1:0] edges, cand, sel, top_isr, new_top;

   function automatic logic [ID_W-1:0] enc(input logic [N_IRQ-1:0] oh);
      logic [ID_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_IRQ; i++)
         if (oh[i]) r = i[ID_W-1:0];
      return r;
   endfunction

   function automatic logic [N_IRQ-1:0] dec(input logic [ID_W-1:0] id);
      logic [N_IRQ-1:0] r;
      r = '0;
      for (int i = 0; i < N_IRQ; i++)
         r[i] = (id == i[ID_W-1:0]);
      return r;
   endfunction

   assign edges   = irq_in & ~prev_irq;
   assign cand    = pending_q & ~mask_q;
   assign sel     = cand & (-cand);
   assign top_isr = isr_q & (-isr_q);

   always_comb begin
      state_n   = state;
      id_n      = id_q;
      pending_n = pending_q;
      isr_n     = isr_q;
      new_top   = '0;
      case (state)
         IDLE: begin
            if (cand != '0) begin
               state_n = REQ;
               id_n    = enc(sel);
            end
         end
         REQ: begin
            if (irq_ack) begin
               pending_n = pending_q & ~dec(id_q);
               isr_n     = isr_q | dec(id_q);
               state_n   = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_eoi) begin
               isr_n   = isr_q & ~top_isr;
               new_top = isr_n & (-isr_n);
`ifdef IRQ_NEST_EN
               // After EOI, a waiting candidate outranking the resumed handler is presented at once
               if ((cand != '0) && ((isr_n == '0) || (enc(sel) < enc(new_top)))) begin
                  state_n = REQ;
                  id_n    = enc(sel);
               end else if (isr_n == '0) begin
                  state_n = IDLE;
               end else begin
                  state_n = SERVICE;
               end
`else
               state_n = IDLE;
`endif
            end
`ifdef IRQ_NEST_EN
            else if ((cand != '0) && (enc(sel) < enc(top_isr))) begin
               state_n = REQ;
               id_n    = enc(sel);
            end
`endif
         end
         default: state_n = IDLE;
      endcase
      // A new edge on the line being acknowledged wins over the clear
      pending_n = pending_n | edges;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pending_q <= '0;
         isr_q     <= '0;
         mask_q    <= '0;
         prev_irq  <= '0;
         id_q      <= '0;
      end else begin
         state     <= state_n;
         pending_q <= pending_n;
         isr_q     <= isr_n;
         prev_irq  <= irq_in;
         id_q      <= id_n;
         if (mask_we) mask_q <= mask_wd;
      end
   end

   assign irq_req    = (state == REQ);
   assign irq_id     = id_q;
   assign irq_onehot = irq_req ? dec(id_q) : '0;
   assign in_service = isr_q;
   assign pending    = pending_q;

endmodule
